// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage to 16-bit async SRAM bridge.
package sram_controller_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int SRAM_ADDR_W       = 18;
  localparam int SRAM_DATA_W       = 16;
  localparam int DEFAULT_BASE_ADDR = 1024;
endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into low/high halfword phases on an async SRAM,
// holding ready low so the pipeline freezes until the word is complete.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   readEn,
  input  logic                   writeEn,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sramAddress,
  output logic [SRAM_DATA_W-1:0] sramDataOut,
  output logic                   sramDataOutEn,
  input  logic [SRAM_DATA_W-1:0] sramDataIn,
  output logic                   sramWeN
);
  localparam int            CW   = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt;
  logic                   op_wr;
  logic [SRAM_DATA_W-1:0] wdata_hi;
  logic                   req, phase_end;
  logic [16:0]            idx;

  assign req       = readEn | writeEn;
  assign phase_end = (cnt == LAST);
  assign idx       = 17'((address - 32'(BASE_ADDR)) >> 2);
  // Combinational so the freeze lands in the same cycle the request shows up.
  assign ready     = (state == DONE) || (state == IDLE && !req);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = LOW;
      LOW:     if (phase_end) state_nx = HIGH;
      HIGH:    if (phase_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pin drivers are registered and loaded one edge ahead of each phase so
  // address, data and WE_N are stable for every cycle of LOW and HIGH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      op_wr         <= 1'b0;
      wdata_hi      <= '0;
      readData      <= '0;
      sramAddress   <= '0;
      sramDataOut   <= '0;
      sramDataOutEn <= 1'b0;
      sramWeN       <= 1'b1;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (req) begin
          cnt           <= '0;
          op_wr         <= writeEn;
          wdata_hi      <= writeData[31:16];
          sramAddress   <= {idx, 1'b0};
          if (writeEn) sramDataOut <= writeData[15:0];
          sramDataOutEn <= writeEn;
          sramWeN       <= ~writeEn;
        end
        LOW: if (phase_end) begin
          cnt         <= '0;
          sramAddress <= {sramAddress[SRAM_ADDR_W-1:1], 1'b1};
          if (op_wr) sramDataOut <= wdata_hi;
          else       readData[15:0] <= sramDataIn;
        end else begin
          cnt <= cnt + CW'(1);
        end
        HIGH: if (phase_end) begin
          cnt           <= '0;
          sramDataOutEn <= 1'b0;
          sramWeN       <= 1'b1;
          if (!op_wr) readData[31:16] <= sramDataIn;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
